// File: rtl/nv_ram_rwsp_fifo_ctrl_pkg.sv
// Shared constants for the rwsp RAM FIFO controller and its output buffer.
package nv_ram_rwsp_fifo_ctrl_pkg;

  localparam int unsigned DEF_DW     = 11;
  localparam int unsigned DEF_AW     = 8;
  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned RAM_RD_LAT = 2;
  localparam int unsigned OBUF_DEPTH = 3;
  localparam int unsigned OBUF_CW    = $clog2(OBUF_DEPTH + 1);

endpackage

// File: rtl/nv_ram_rwsp_fifo_obuf.sv
// Small flop FIFO that absorbs RAM read data; entry 0 is always the head so
// the head output comes straight from a flop.
module nv_ram_rwsp_fifo_obuf
  import nv_ram_rwsp_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DW-1:0]      push_data,
  input  logic               pop,
  output logic [OBUF_CW-1:0] cnt,
  output logic [DW-1:0]      head
);

  logic [DW-1:0]      mem_q [OBUF_DEPTH];
  logic [DW-1:0]      mem_d [OBUF_DEPTH];
  logic [OBUF_CW-1:0] cnt_q;
  logic [OBUF_CW-1:0] cnt_d;
  logic [OBUF_CW-1:0] wr_idx;

  // Pop shifts toward the head; push lands behind the last surviving entry.
  always_comb begin
    mem_d  = mem_q;
    cnt_d  = cnt_q + OBUF_CW'(push) - OBUF_CW'(pop);
    wr_idx = cnt_q - OBUF_CW'(pop);
    if (pop) begin
      for (int i = 0; i < int'(OBUF_DEPTH) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
        if (OBUF_CW'(i) == wr_idx) begin
          mem_d[i] = push_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign cnt  = cnt_q;
  assign head = mem_q[0];

endmodule

// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// Valid/ready FIFO controller for a 256x11 rwsp RAM, hiding its 2-cycle read.
// Define NV_RAM_RWSP_FIFO_CTRL_COUNT_EN to add the fifo_cnt occupancy output.
module nv_ram_rwsp_fifo_ctrl
  import nv_ram_rwsp_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_ram_pd
`ifdef NV_RAM_RWSP_FIFO_CTRL_COUNT_EN
  ,
  output logic [AW+1:0] fifo_cnt
`endif
);

  localparam int unsigned CW  = AW + 1;
  localparam int unsigned IFW = $clog2(RAM_RD_LAT + 1);
  localparam int unsigned CRW = OBUF_CW + 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  logic [RAM_RD_LAT-1:0] tok_q, tok_d;
  logic                  wr_prdy_q, wr_prdy_d;
  logic                  wr_acc, issue, pop, push;
  logic [IFW-1:0]        inflight;
  logic [CRW-1:0]        credit;
  logic [OBUF_CW-1:0]    obuf_cnt;
  logic [DW-1:0]         obuf_head;

  // A pop this cycle frees a slot before the new read can land, so it may
  // cover a fully committed buffer and keep streaming at one word per cycle.
  always_comb begin
    wr_acc   = wr_pvld & wr_prdy_q;
    pop      = (obuf_cnt != '0) & rd_prdy;
    push     = tok_q[RAM_RD_LAT-1];
    inflight = '0;
    for (int i = 0; i < int'(RAM_RD_LAT); i++) begin
      inflight = inflight + IFW'(tok_q[i]);
    end
    credit    = CRW'(inflight) + CRW'(obuf_cnt);
    issue     = (ram_cnt_q != '0) && ((credit < CRW'(OBUF_DEPTH)) || pop);
    tok_d     = {tok_q[RAM_RD_LAT-2:0], issue};
    wr_ptr_d  = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d  = rd_ptr_q + AW'(issue);
    ram_cnt_d = ram_cnt_q + CW'(wr_acc) - CW'(issue);
    wr_prdy_d = (ram_cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      tok_q     <= '0;
      wr_prdy_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      tok_q     <= tok_d;
      wr_prdy_q <= wr_prdy_d;
    end
  end

  nv_ram_rwsp_fifo_obuf #(
    .DW (DW)
  ) u_obuf (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .push      (push),
    .push_data (ram_dout),
    .pop       (pop),
    .cnt       (obuf_cnt),
    .head      (obuf_head)
  );

  assign wr_prdy           = wr_prdy_q;
  assign ram_we            = wr_acc;
  assign ram_wa            = wr_ptr_q;
  assign ram_di            = wr_pd;
  assign ram_re            = issue;
  assign ram_ra            = rd_ptr_q;
  assign ram_ore           = tok_q[0];
  assign rd_pvld           = (obuf_cnt != '0);
  assign rd_pd             = obuf_head;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

`ifdef NV_RAM_RWSP_FIFO_CTRL_COUNT_EN
  localparam int unsigned FCW = AW + 2;

  logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [IFW-1:0] inflight_d;

  // Total words held: RAM, read pipeline and output buffer, as of next cycle.
  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < int'(RAM_RD_LAT); i++) begin
      inflight_d = inflight_d + IFW'(tok_d[i]);
    end
    fifo_cnt_d = FCW'(ram_cnt_d) + FCW'(inflight_d) + FCW'(obuf_cnt)
               + FCW'(push) - FCW'(pop);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      fifo_cnt_q <= '0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign fifo_cnt = fifo_cnt_q;
`endif

endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl.sv
// Randomized and directed bench for nv_ram_rwsp_fifo_ctrl with a RAM model
// and a queue-based reference of FIFO occupancy and ordering.
module tb_nv_ram_rwsp_fifo_ctrl;

  localparam int DW    = 11;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int OBUF  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [DW-1:0] wr_pd, rd_pd, ram_di, ram_dout;
  logic [AW-1:0] ram_wa, ram_ra;
  logic          ram_we, ram_re, ram_ore;
  logic [31:0]   pwrbus, ram_pwrbus;

  always #5 clk = ~clk;

  nv_ram_rwsp_fifo_ctrl dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rst_n),
    .wr_pvld           (wr_pvld),
    .wr_prdy           (wr_prdy),
    .wr_pd             (wr_pd),
    .rd_pvld           (rd_pvld),
    .rd_prdy           (rd_prdy),
    .rd_pd             (rd_pd),
    .ram_wa            (ram_wa),
    .ram_we            (ram_we),
    .ram_di            (ram_di),
    .ram_ra            (ram_ra),
    .ram_re            (ram_re),
    .ram_ore           (ram_ore),
    .ram_dout          (ram_dout),
    .pwrbus_ram_pd     (pwrbus),
    .ram_pwrbus_ram_pd (ram_pwrbus)
  );

  // RAM: write array, latch read address on re, register data on ore.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_l;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_l <= ram_ra;
    if (ram_ore) ram_dout <= mem[ra_l];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference: words queued, words in RAM, reads issued but not consumed.
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_pd;
  int  ram_cnt_m = 0, out_m = 0, obuf_m = 0, wr_n = 0, rd_n = 0;
  int  acc_total = 0, pop_total = 0;
  bit  re_d1 = 0, re_d2 = 0, acc_m, pop_m;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check_eq("rst_we", ram_we, 0);
        check_eq("rst_re", ram_re, 0);
        check_eq("rst_ore", ram_ore, 0);
        check_eq("rst_pvld", rd_pvld, 0);
        check_eq("rst_prdy", wr_prdy, 0);
        check_eq("rst_wa", ram_wa, 0);
        check_eq("rst_ra", ram_ra, 0);
        check_eq("rst_pd", rd_pd, 0);
        sb.delete();
        ram_cnt_m = 0; out_m = 0; obuf_m = 0; wr_n = 0; rd_n = 0;
        re_d1 = 0; re_d2 = 0;
      end else begin
        acc_m = wr_pvld && (ram_cnt_m != DEPTH);
        pop_m = rd_prdy && (obuf_m != 0);
        check_eq("wr_prdy", wr_prdy, ram_cnt_m != DEPTH);
        check_eq("ram_we", ram_we, acc_m);
        if (acc_m) begin
          check_eq("ram_wa", ram_wa, wr_n % DEPTH);
          check_eq("ram_di", ram_di, wr_pd);
          sb.push_back(wr_pd);
        end
        check_eq("rd_pvld", rd_pvld, obuf_m != 0);
        check_eq("ram_ore", ram_ore, re_d1);
        if (ram_re) begin
          check_eq("ram_ra", ram_ra, rd_n % DEPTH);
          check_eq("re_legal", (ram_cnt_m > 0) && (out_m - int'(pop_m) < OBUF), 1);
        end
        if (pop_m) begin
          exp_pd = (sb.size() != 0) ? sb.pop_front() : 'x;
          check_eq("rd_pd", rd_pd, exp_pd);
          pop_total++;
        end
        ram_cnt_m += int'(acc_m) - int'(ram_re);
        out_m     += int'(ram_re) - int'(pop_m);
        obuf_m    += int'(re_d2) - int'(pop_m);
        if (acc_m)  begin wr_n++; acc_total++; end
        if (ram_re) rd_n++;
        re_d2 = re_d1;
        re_d1 = ram_re;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    wr_pvld = 0;
    rd_prdy = 1;
    while ((sb.size() != 0 || obuf_m != 0) && n < 2000) begin
      step();
      n++;
    end
    check_eq(tag, sb.size(), 0);
    @(negedge clk);
    check_eq({tag, "_pvld"}, rd_pvld, 0);
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int a0, p0, p1, n;

  initial begin
    wr_pvld = 0; rd_prdy = 0; wr_pd = '0; pwrbus = 32'hA5C3_0F1E;
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    step();
    check_eq("pwrbus", ram_pwrbus, 32'hA5C3_0F1E);

    // Single word latency from an empty FIFO.
    wr_pvld = 1; wr_pd = 11'h5A5; rd_prdy = 1;
    @(negedge clk);
    check_eq("t1_we", ram_we, 1);
    check_eq("t1_wa", ram_wa, 0);
    step(); wr_pvld = 0;
    @(negedge clk); check_eq("t1_re", ram_re, 1);
    step();
    @(negedge clk); check_eq("t1_ore", ram_ore, 1); check_eq("t1_pvld2", rd_pvld, 0);
    step();
    @(negedge clk); check_eq("t1_pvld3", rd_pvld, 0);
    step();
    @(negedge clk); check_eq("t1_pvld4", rd_pvld, 1); check_eq("t1_pd", rd_pd, 11'h5A5);
    step();
    drain("t1_drain");

    // Backpressure: 300 offered writes with the consumer stalled.
    rd_prdy = 0; wr_pvld = 1; a0 = acc_total;
    for (int i = 0; i < 300; i++) begin
      wr_pd = DW'($urandom);
      step();
    end
    wr_pvld = 0;
    check_eq("bp_accepts", acc_total - a0, 259);
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_prdy", wr_prdy, 0);
      check_eq("bp_full_pvld", rd_pvld, 1);
      check_eq("bp_no_ore", ram_ore, 0);
    end
    step();
    drain("bp_drain");

    // Streaming incrementing words with both sides always ready.
    wr_pvld = 1; rd_prdy = 1; a0 = acc_total; n = 0; p0 = 0; p1 = 0;
    while (acc_total - a0 < 1000 && n < 3000) begin
      wr_pd = DW'(acc_total - a0);
      if (n == 20)  p0 = pop_total;
      if (n == 980) p1 = pop_total;
      step();
      n++;
    end
    check_eq("st_words", acc_total - a0, 1000);
    check_eq("st_rate", p1 - p0, 960);
    drain("st_drain");

    // Fill to capacity, then write alongside issues at the full boundary.
    rd_prdy = 0; wr_pvld = 1; n = 0;
    while (ram_cnt_m != DEPTH && n < 400) begin
      wr_pd = DW'($urandom);
      step();
      n++;
    end
    rd_prdy = 1; wr_pd = DW'($urandom);
    @(negedge clk); check_eq("fs_prdy0", wr_prdy, 0); check_eq("fs_re0", ram_re, 1);
    step(); wr_pd = DW'($urandom);
    @(negedge clk);
    check_eq("fs_prdy1", wr_prdy, 1); check_eq("fs_re1", ram_re, 1); check_eq("fs_we1", ram_we, 1);
    step(); rd_prdy = 0; wr_pd = DW'($urandom);
    @(negedge clk);
    check_eq("fs_prdy2", wr_prdy, 1); check_eq("fs_we2", ram_we, 1); check_eq("fs_re2", ram_re, 0);
    step(); wr_pvld = 0;
    @(negedge clk); check_eq("fs_prdy3", wr_prdy, 0);
    step();
    drain("fs_drain");

    // Random valid/ready at 50% over 10k words.
    a0 = acc_total; n = 0;
    while (acc_total - a0 < 10000 && n < 60000) begin
      wr_pvld = 1'($urandom_range(0, 1));
      rd_prdy = 1'($urandom_range(0, 1));
      wr_pd   = DW'($urandom);
      step();
      n++;
    end
    check_eq("rnd_words", acc_total - a0, 10000);
    drain("rnd_drain");

    // Reset with two reads in flight.
    rd_prdy = 0; wr_pvld = 1; wr_pd = 11'h0AB;
    step(); wr_pd = 11'h0CD;
    step(); wr_pvld = 0;
    step();
    check_eq("rm_ore_pre", ram_ore, 1);
    #1 rst_n = 0;
    #1;
    check_eq("rm_we", ram_we, 0);
    check_eq("rm_re", ram_re, 0);
    check_eq("rm_ore", ram_ore, 0);
    check_eq("rm_pvld", rd_pvld, 0);
    check_eq("rm_prdy", wr_prdy, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    step();
    repeat (4) begin
      @(negedge clk);
      check_eq("rm_empty", rd_pvld, 0);
    end
    step();
    pwrbus = 32'h1357_9BDF;
    wr_pvld = 1; wr_pd = 11'h123; rd_prdy = 1;
    @(negedge clk); check_eq("rm_wa", ram_wa, 0); check_eq("pwrbus2", ram_pwrbus, 32'h1357_9BDF);
    step(); wr_pvld = 0;
    p0 = pop_total; n = 0;
    while (pop_total == p0 && n < 10) begin
      step();
      n++;
    end
    check_eq("rm_roundtrip", pop_total - p0, 1);
    drain("rm_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
